// File: rtl/kfpcjr_kb_pkg.sv
// rtl/kfpcjr_kb_pkg.sv - shared IR keyboard link types and defaults
// Used by both the IR encoder and the IR decoder.
package kfpcjr_kb_pkg;

  localparam logic [15:0] default_bit_cycle  = 16'd22000;
  localparam logic [3:0]  default_stop_cells = 4'd2;

  typedef enum logic [2:0] {
    st_idle      = 3'd0,
    st_start     = 3'd1,
    st_data      = 3'd2,
    st_parity    = 3'd3,
    st_stop      = 3'd4,
    st_wait_idle = 3'd5
  } kb_state_t;

  // Odd parity over data plus parity bit: 1 means the frame is consistent.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/kfpcjr_ir_cell_timer.sv
// rtl/kfpcjr_ir_cell_timer.sv - biphase bit-cell timer with quarter/three-quarter sample strobes
// Held at zero while restart is high; free-runs modulo bit_cycle otherwise.
module kfpcjr_ir_cell_timer #(
  parameter int bit_cycle = 22000,
  parameter int cnt_w     = $clog2(bit_cycle)
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic sample_a,
  output logic sample_b,
  output logic cell_end
);

  localparam logic [cnt_w-1:0] a_point   = cnt_w'(bit_cycle / 4);
  localparam logic [cnt_w-1:0] b_point   = cnt_w'((3 * bit_cycle) / 4);
  localparam logic [cnt_w-1:0] end_point = cnt_w'(bit_cycle - 1);

  logic [cnt_w-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || cnt == end_point) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sample_a = !restart && (cnt == a_point);
  assign sample_b = !restart && (cnt == b_point);
  assign cell_end = !restart && (cnt == end_point);

endmodule

// File: rtl/kfpcjr_ir_kb_decoder.sv
// rtl/kfpcjr_ir_kb_decoder.sv - PCjr IR keyboard biphase receiver with one-byte holding register
// Synchronizer, frame FSM, shift/parity accumulation and valid/ack holding register.
module kfpcjr_ir_kb_decoder
  import kfpcjr_kb_pkg::*;
#(
  parameter logic [15:0] bit_cycle  = default_bit_cycle,
  parameter logic [3:0]  stop_cells = default_stop_cells
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ir_signal,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int cnt_w = $clog2(int'(bit_cycle));
  localparam logic [cnt_w-1:0] wait_last = cnt_w'(bit_cycle - 16'd1);

  logic            s_meta, s, s_prev, s_rise;
  kb_state_t       state;
  logic [2:0]      bit_idx;
  logic [3:0]      stop_idx;
  logic            smp_a;
  logic [7:0]      shift;
  logic            par_acc;
  logic            par_bad;
  logic [cnt_w-1:0] wait_cnt;
  logic            timer_restart, sample_a, sample_b, cell_end, phase_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s_meta <= ir_signal;
      s      <= s_meta;
      s_prev <= s;
    end
  end

  assign s_rise = s && !s_prev;

  // The timer keeps cnt at 0 through IDLE so that the rising cycle is cnt==0.
  assign timer_restart = ((state == st_idle) && !s_rise) || (state == st_wait_idle);

  kfpcjr_ir_cell_timer #(
    .bit_cycle (int'(bit_cycle)),
    .cnt_w     (cnt_w)
  ) u_cell_timer (
    .clock    (clock),
    .reset    (reset),
    .restart  (timer_restart),
    .sample_a (sample_a),
    .sample_b (sample_b),
    .cell_end (cell_end)
  );

  assign phase_err = sample_b && (smp_a == s);
  assign busy      = (state != st_idle);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= st_idle;
      bit_idx       <= '0;
      stop_idx      <= '0;
      smp_a         <= 1'b0;
      shift         <= '0;
      par_acc       <= 1'b0;
      par_bad       <= 1'b0;
      wait_cnt      <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state)
        st_idle: begin
          if (s_rise) begin
            state    <= st_start;
            bit_idx  <= '0;
            stop_idx <= '0;
            par_acc  <= 1'b0;
          end
        end

        st_start: begin
          if (sample_a) smp_a <= s;
          if (phase_err || (sample_b && !smp_a)) begin
            frame_err <= 1'b1;
            wait_cnt  <= '0;
            state     <= st_wait_idle;
          end else if (cell_end) begin
            state <= st_data;
          end
        end

        st_data: begin
          if (sample_a) smp_a <= s;
          if (phase_err) begin
            frame_err <= 1'b1;
            wait_cnt  <= '0;
            state     <= st_wait_idle;
          end else begin
            // Bits arrive LSB first, so shift in from the top.
            if (sample_b) begin
              shift   <= {smp_a, shift[7:1]};
              par_acc <= par_acc ^ smp_a;
            end
            if (cell_end) begin
              if (bit_idx == 3'd7) state <= st_parity;
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        st_parity: begin
          if (sample_a) smp_a <= s;
          if (phase_err) begin
            frame_err <= 1'b1;
            wait_cnt  <= '0;
            state     <= st_wait_idle;
          end else begin
            if (sample_b) par_bad <= !(par_acc ^ smp_a);
            if (cell_end) state <= st_stop;
          end
        end

        st_stop: begin
          if ((sample_a || sample_b) && s) begin
            frame_err <= 1'b1;
            wait_cnt  <= '0;
            state     <= st_wait_idle;
          end else if (cell_end) begin
            if (stop_idx == stop_cells - 4'd1) begin
              state <= st_idle;
              if (!rx_valid || rx_ack) begin
                rx_data       <= shift;
                rx_parity_err <= par_bad;
                rx_valid      <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
            stop_idx <= stop_idx + 4'd1;
          end
        end

        st_wait_idle: begin
          if (s) begin
            wait_cnt <= '0;
          end else if (wait_cnt == wait_last) begin
            state <= st_idle;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_kfpcjr_ir_kb_decoder.sv
// tb/tb_kfpcjr_ir_kb_decoder.sv - self-checking bench for the IR keyboard decoder
// Frames are built as per-clock level sequences from the cell encoding rules.
module tb_kfpcjr_ir_kb_decoder;

  localparam int bc = 40;
  localparam int sc = 2;
  localparam int frame_clks = bc * (10 + sc) + 10;
  localparam int exp_latency = 2 + bc * (10 + sc);

  logic       clock = 1'b0;
  logic       reset;
  logic       ir_signal;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fe_count = 0;
  int fe_cyc = -1;
  int rise_cyc = -1;
  logic valid_q = 1'b0;
  logic lv[$];
  logic last_pbit;

  kfpcjr_ir_kb_decoder #(
    .bit_cycle  (16'(bc)),
    .stop_cells (4'(sc))
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ir_signal     (ir_signal),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ack        (rx_ack),
    .rx_parity_err (rx_parity_err),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (frame_err) begin
      fe_count = fe_count + 1;
      fe_cyc = cyc;
    end
    if (rx_valid && !valid_q) rise_cyc = cyc;
    valid_q = rx_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cells: start(1), 8 data LSB first, odd parity. bad_cell >= 0 ends the frame at that cell, held high.
  task automatic build(input logic [7:0] d, input bit flip_par, input int bad_cell);
    logic [9:0] bits;
    int last;
    bits[0] = 1'b1;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9] = ((($countones(d) % 2) == 0) ? 1'b1 : 1'b0) ^ flip_par;
    last_pbit = bits[9];
    last = (bad_cell >= 0) ? bad_cell : 9;
    lv.delete();
    for (int c = 0; c <= last; c++)
      for (int k = 0; k < bc; k++)
        lv.push_back((c == bad_cell) ? 1'b1 : ((k < bc / 2) ? bits[c] : ~bits[c]));
  endtask

  task automatic play(input int n_clk, input int ack_at);
    for (int i = 0; i < n_clk; i++) begin
      ir_signal = (i < lv.size()) ? lv[i] : 1'b0;
      rx_ack = (i == ack_at);
      @(posedge clock); #1;
    end
    rx_ack = 1'b0;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(posedge clock); #1;
    rx_ack = 1'b0;
  endtask

  initial begin
    int c0;
    logic [7:0] d;
    bit flip;
    logic exp_perr;
    reset = 1'b1;
    ir_signal = 1'b0;
    rx_ack = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_parity_err", 32'(rx_parity_err), 0);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;

    // Test 1: good frame, latency and no frame error
    fe_count = 0;
    rise_cyc = -1;
    build(8'h1E, 1'b0, -1);
    c0 = cyc;
    play(frame_clks, -1);
    check("t1_latency", 32'(rise_cyc - c0), 32'(exp_latency));
    check("t1_valid", 32'(rx_valid), 1);
    check("t1_data", 32'(rx_data), 32'h1E);
    check("t1_perr", 32'(rx_parity_err), 0);
    check("t1_no_frame_err", 32'(fe_count), 0);
    check("t1_busy", 32'(busy), 0);
    ack_pulse();
    check("t1_ack_clears", 32'(rx_valid), 0);

    // Test 2: inverted parity cell
    build(8'h55, 1'b1, -1);
    play(frame_clks, -1);
    check("t2_valid", 32'(rx_valid), 1);
    check("t2_data", 32'(rx_data), 32'h55);
    check("t2_perr", 32'(rx_parity_err), 1);
    ack_pulse();

    // Test 3: data cell 3 (cell 4 of frame) high both halves, then 40 lows and a good frame
    fe_count = 0;
    build(8'hFF, 1'b0, 4);
    c0 = cyc;
    play(5 * bc + bc, -1);
    check("t3_fe_count", 32'(fe_count), 1);
    check("t3_fe_time", 32'(fe_cyc - c0), 32'(2 + 4 * bc + (3 * bc) / 4 + 1));
    check("t3_no_valid", 32'(rx_valid), 0);
    build(8'hAA, 1'b0, -1);
    play(frame_clks, -1);
    check("t3_next_valid", 32'(rx_valid), 1);
    check("t3_next_data", 32'(rx_data), 32'hAA);
    check("t3_next_perr", 32'(rx_parity_err), 0);
    check("t3_single_fe", 32'(fe_count), 1);
    ack_pulse();

    // Test 4: overrun
    build(8'h01, 1'b0, -1);
    play(frame_clks, -1);
    build(8'h02, 1'b0, -1);
    play(frame_clks, -1);
    check("t4_valid", 32'(rx_valid), 1);
    check("t4_data_held", 32'(rx_data), 32'h01);
    check("t4_overrun", 32'(overrun), 1);
    ack_pulse();
    check("t4_ack_valid", 32'(rx_valid), 0);
    check("t4_ack_overrun", 32'(overrun), 0);

    // Test 5: ack in the delivery cycle of the second frame
    build(8'h18, 1'b0, -1);
    play(frame_clks, -1);
    check("t5_first_data", 32'(rx_data), 32'h18);
    build(8'h81, 1'b0, -1);
    play(frame_clks, exp_latency - 1);
    check("t5_valid", 32'(rx_valid), 1);
    check("t5_data", 32'(rx_data), 32'h81);
    check("t5_overrun", 32'(overrun), 0);
    ack_pulse();

    // Test 6: reset in the middle of DATA
    build(8'h3C, 1'b0, -1);
    play(3 * bc + 5, -1);
    check("t6_busy_before", 32'(busy), 1);
    ir_signal = 1'b0;
    reset = 1'b1;
    #2;
    check("t6_busy", 32'(busy), 0);
    check("t6_outputs", 32'({rx_data, rx_valid, rx_parity_err, frame_err, overrun}), 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    build(8'h3C, 1'b0, -1);
    play(frame_clks, -1);
    check("t6_valid", 32'(rx_valid), 1);
    check("t6_data", 32'(rx_data), 32'h3C);
    check("t6_perr", 32'(rx_parity_err), 0);
    ack_pulse();

    // Randomized frames against the parity rule
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom);
      flip = 1'($urandom_range(0, 1));
      build(d, flip, -1);
      exp_perr = (($countones(d) + int'(last_pbit)) % 2) == 0;
      play(frame_clks, -1);
      check("rnd_data", 32'(rx_data), 32'(d));
      check("rnd_perr", 32'(rx_parity_err), 32'(exp_perr));
      repeat ($urandom_range(0, 20)) @(posedge clock);
      #1;
      ack_pulse();
      check("rnd_ack", 32'(rx_valid), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
